// File: rtl/train_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : train_scheduler
//  Description : Walks every sample of the dataset through EPOCH_MAX+1 epochs.
//                Each step is offered to the update datapath over a
//                valid/ready handshake; the next step is issued after the
//                datapath's step-complete pulse. The learning rate is a
//                registered lookup of the epoch, loaded with the epoch.
//  Revision    : 1.0 - initial release
// ============================================================================
module train_scheduler #(
    parameter int inst_sig_width = 23,
    parameter int inst_exp_width = 8,
    parameter int EPOCH_MAX      = 24,
    parameter int SAMPLES        = 100
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   step_valid,
    input  logic                                   step_ready,
    input  logic                                   step_done,
    output logic [$clog2(SAMPLES)-1:0]             sample_idx,
    output logic [$clog2(EPOCH_MAX):0]             epoch,
    output logic [inst_sig_width+inst_exp_width:0] lr,
    output logic                                   busy,
    output logic                                   done
);

    localparam int c_SW = $clog2(SAMPLES);
    localparam int c_EW = $clog2(EPOCH_MAX) + 1;
    localparam int c_LW = inst_sig_width + inst_exp_width + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_SW-1:0] c_SAMPLE_LAST = c_SW'(SAMPLES - 1);
    localparam logic [c_EW-1:0] c_EPOCH_LAST  = c_EW'(EPOCH_MAX);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_SW-1:0] r_sample_idx;
    logic [c_SW-1:0] w_sample_next;
    logic [c_EW-1:0] r_epoch;
    logic [c_EW-1:0] w_epoch_next;
    logic [c_LW-1:0] r_lr;

    // Learning-rate schedule: one value per group of four epochs, with the
    // final epoch (24) getting its own step down; anything else reads zero.
    function automatic logic [c_LW-1:0] lr_lookup(input logic [c_EW-1:0] ep);
        logic [31:0] v_e32;
        logic [31:0] v_lr;
        v_e32 = 32'(ep);
        v_lr  = 32'h0;
        if (v_e32 == 32'd24) begin
            v_lr = 32'h328637bd;
        end else begin
            case (v_e32 >> 2)
                32'd0:   v_lr = 32'h358637bd;
                32'd1:   v_lr = 32'h350637bd;
                32'd2:   v_lr = 32'h348637bd;
                32'd3:   v_lr = 32'h340637bd;
                32'd4:   v_lr = 32'h338637bd;
                32'd5:   v_lr = 32'h330637bd;
                default: v_lr = 32'h0;
            endcase
        end
        return c_LW'(v_lr);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, counter advance and state-decoded outputs; abort overrides all.
    always_comb begin
        w_state_next  = r_state;
        w_sample_next = r_sample_idx;
        w_epoch_next  = r_epoch;
        step_valid    = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy          = 1'b0;
                w_sample_next = '0;
                w_epoch_next  = '0;
                if (start) begin
                    w_state_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                step_valid = 1'b1;
                if (step_ready) begin
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (step_done) begin
                    if (r_sample_idx < c_SAMPLE_LAST) begin
                        w_sample_next = r_sample_idx + c_SW'(1);
                        w_state_next  = c_ISSUE;
                    end else if (r_epoch < c_EPOCH_LAST) begin
                        w_sample_next = '0;
                        w_epoch_next  = r_epoch + c_EW'(1);
                        w_state_next  = c_ISSUE;
                    end else begin
                        w_state_next = c_DONE;
                    end
                end
            end
            c_DONE: begin
                done          = 1'b1;
                w_sample_next = '0;
                w_epoch_next  = '0;
                w_state_next  = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next  = c_IDLE;
            w_sample_next = '0;
            w_epoch_next  = '0;
        end
    end

    // Step counters; lr is loaded from the same next-epoch value so the two
    // always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_idx <= '0;
            r_epoch      <= '0;
            r_lr         <= lr_lookup('0);
        end else begin
            r_sample_idx <= w_sample_next;
            r_epoch      <= w_epoch_next;
            r_lr         <= lr_lookup(w_epoch_next);
        end
    end

    assign sample_idx = r_sample_idx;
    assign epoch      = r_epoch;
    assign lr         = r_lr;

endmodule
`default_nettype wire

// File: doc/train_scheduler.md
# train_scheduler

Sequencer for the Lab04 training datapath. On a start pulse it walks every sample of the current dataset through EPOCH_MAX+1 epochs. For each training step it presents the sample index, epoch number and learning rate to the update datapath over a valid/ready handshake, then waits for the datapath's step-complete pulse. It owns the learning-rate schedule: the LR for each step is a registered lookup of the current epoch.

## Interface
- inst_sig_width, 23, significand width of IEEE-754 operands
- inst_exp_width, 8, exponent width of IEEE-754 operands
- EPOCH_MAX, 24, index of last epoch (epochs 0..EPOCH_MAX run, 25 total)
- SAMPLES, 100, samples per epoch (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a training run; honoured only in IDLE
- abort  in  1  cancels a run; highest priority after rst
- step_valid  out  1  step request to datapath
- step_ready  in  1  datapath accepts request when step_valid && step_ready
- step_done  in  1  one-cycle pulse, datapath finished the accepted step
- sample_idx  out  $clog2(SAMPLES)  sample for current step
- epoch  out  $clog2(EPOCH_MAX)+1  epoch for current step
- lr  out  inst_sig_width+inst_exp_width+1  learning rate for current step
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle pulse, run finished normally

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: counters held at 0. start=1 → ISSUE, with sample_idx=0, epoch=0, lr=LR(0).
- ISSUE: step_valid=1. sample_idx, epoch and lr stay stable until the handshake. step_ready=1 → WAIT.
- WAIT: step_valid=0. On step_done=1:
  - If sample_idx<SAMPLES-1: sample_idx+1, then ISSUE.
  - Else if epoch<EPOCH_MAX: sample_idx=0, epoch+1, then ISSUE.
  - Else: DONE.
- DONE: done=1 for exactly one cycle. Then IDLE, with counters cleared to 0.
- step_done outside WAIT is ignored. step_ready outside ISSUE is ignored. start outside IDLE is ignored (no queuing).
- abort=1 in any state → IDLE next cycle. Counters clear to 0, done is not asserted, and an outstanding step is abandoned.
- LR schedule, keyed by epoch>>2, registered together with epoch:
  - group 0: 32'h358637bd (1e-6)
  - group 1: 32'h350637bd
  - group 2: 32'h348637bd
  - group 3: 32'h340637bd
  - group 4: 32'h338637bd
  - group 5: 32'h330637bd
  - epoch==24: 32'h328637bd (1.5625e-8)
  - any other value: 0
- Total accepted steps per run: (EPOCH_MAX+1)*SAMPLES, i.e. 2500 at defaults.
- Reset values (rst=1, next edge): state IDLE, step_valid=0, busy=0, done=0, sample_idx=0, epoch=0, lr=32'h358637bd. rst wins over every other input.

## Timing
- start sampled at edge t → step_valid=1 and busy=1 from t+1.
- Handshake at edge t → step_valid=0 from t+1. Minimum of one WAIT cycle; a step_done at edge t+1 is legal.
- step_done at edge t → next step_valid=1 at t+1, with updated sample_idx, epoch and lr in the same cycle.
- Last step_done at edge t → done=1 and busy=1 at t+1. IDLE at t+2 (busy=0); start accepted from t+2.
- lr always matches epoch in the same cycle; there is no extra pipeline stage.
- step_ready held high permanently gives a throughput of one step per 2 cycles plus the datapath latency.

## Test plan
- Reset with SAMPLES=4, EPOCH_MAX=24 → outputs match the reset values. start at cycle 5 → step_valid=1 at cycle 6 with sample_idx=0, epoch=0, lr=32'h358637bd.
- Full run, SAMPLES=4, step_ready=1, step_done 1 cycle after each acceptance → exactly 100 handshakes; epoch increments after every 4th step_done; one done pulse.
- LR boundaries → lr=32'h358637bd at epoch 3, 32'h350637bd at epoch 4, 32'h330637bd at epoch 23, 32'h328637bd at epoch 24. Changes occur on the same cycle as epoch.
- Backpressure: step_ready held 0 for 7 cycles in ISSUE → step_valid, sample_idx and lr held stable; a stray step_done during ISSUE does not advance the counters.
- abort in WAIT at epoch 10, sample 2 → IDLE next cycle, busy=0, epoch=0, no done. A following start restarts from epoch 0, sample 0.
- start pulsed during busy, and rst asserted mid-run at epoch 5 → the start is ignored; rst yields reset values at the next edge and no done.
